// File: rtl/ariane_axi.sv
// ariane_axi: AXI4 channel types for the core memory port.
// Widths: 64-bit address, 64-bit data, 4-bit ID, 1-bit user.
// req_t carries master-driven channels (AW, W, AR, B/R readies).
// resp_t carries slave-driven channels (AW/W/AR readies, B, R).
package ariane_axi;

   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned IdWidth   = 4;
   localparam int unsigned UserWidth = 1;
   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [5:0]           atop;
      logic [UserWidth-1:0] user;
   } aw_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      logic                 last;
      logic [UserWidth-1:0] user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [1:0]           resp;
      logic [UserWidth-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [UserWidth-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/axi_shared_port_arbiter_if.sv
// axi_shared_port_arbiter_if: one ariane_axi memory port.
//   axi_req  - request channels, driven by the master
//   axi_resp - response channels, driven by the slave
// Modports: master (drives axi_req), slave (drives axi_resp).
interface axi_shared_port_arbiter_if;

   ariane_axi::req_t  axi_req;
   ariane_axi::resp_t axi_resp;

   modport master (output axi_req, input axi_resp);
   modport slave  (input axi_req, output axi_resp);

endinterface

// File: rtl/axi_shared_port_arbiter.sv
// axi_shared_port_arbiter: shares one AXI4 master port between two
// load/store requesters. Each accepted request becomes one single-beat
// 64-bit read or write; only one transaction is outstanding at a time.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  per-requester request handshake (ready = accept pulse)
//   req_we_i/addr/wdata/be   per-requester request payload, slice i = requester i
//   rsp_valid_o              per-requester one-cycle response pulse
//   rsp_rdata_o/rsp_err_o    shared response data and error, held until next response
//   axi                      AXI master port (axi_req out, axi_resp in)
module axi_shared_port_arbiter #(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0]                 req_we_i,
   input  logic [2*AddrWidth-1:0]     req_addr_i,
   input  logic [2*DataWidth-1:0]     req_wdata_i,
   input  logic [2*DataWidth/8-1:0]   req_be_i,
   output logic [1:0]                 rsp_valid_o,
   output logic [DataWidth-1:0]       rsp_rdata_o,
   output logic                       rsp_err_o,
   axi_shared_port_arbiter_if.master  axi
);

   localparam int unsigned StrbWidth = DataWidth / 8;

   typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_e;

   state_e                state_q, state_d;
   logic                  last_q;
   logic                  idx_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [DataWidth-1:0]  wdata_q;
   logic [StrbWidth-1:0]  be_q;
   logic                  aw_done_q, w_done_q;
   logic [1:0]            rsp_valid_q;
   logic [DataWidth-1:0]  rsp_rdata_q;
   logic                  rsp_err_q;

   logic                  winner;
   logic                  accept;
   logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic                  aw_fin, w_fin;

   // Response fields the block deliberately ignores.
   logic                  unused_resp_bits;
   assign unused_resp_bits = ^{axi.axi_resp.r.id, axi.axi_resp.r.last, axi.axi_resp.r.user,
                               axi.axi_resp.r.resp[0], axi.axi_resp.b.id,
                               axi.axi_resp.b.user, axi.axi_resp.b.resp[0]};

   // Round-robin: on a tie the requester not granted last time wins.
   always_comb begin
      winner = req_valid_i[1];
      if (req_valid_i == 2'b11) winner = ~last_q;
   end

   assign accept = (state_q == IDLE) && (|req_valid_i);

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[winner] = 1'b1;
   end

   assign ar_hs = axi.axi_req.ar_valid & axi.axi_resp.ar_ready;
   assign r_hs  = axi.axi_req.r_ready  & axi.axi_resp.r_valid;
   assign aw_hs = axi.axi_req.aw_valid & axi.axi_resp.aw_ready;
   assign w_hs  = axi.axi_req.w_valid  & axi.axi_resp.w_ready;
   assign b_hs  = axi.axi_req.b_ready  & axi.axi_resp.b_valid;

   // A write channel counts as finished if it completed earlier or completes now,
   // so simultaneous AW/W handshakes advance in a single cycle.
   assign aw_fin = aw_done_q | aw_hs;
   assign w_fin  = w_done_q  | w_hs;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = req_we_i[winner] ? WR : AR;
         AR:   if (ar_hs) state_d = R;
         R:    if (r_hs) state_d = IDLE;
         WR:   if (aw_fin && w_fin) state_d = B;
         B:    if (b_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // AXI request channels are decoded from state and latched payload only;
   // fields outside the active state stay zero.
   always_comb begin
      axi.axi_req = '0;
      case (state_q)
         AR: begin
            axi.axi_req.ar_valid  = 1'b1;
            axi.axi_req.ar.id     = {{(IdWidth-1){1'b0}}, idx_q};
            axi.axi_req.ar.addr   = addr_q;
            axi.axi_req.ar.size   = 3'd3;
            axi.axi_req.ar.burst  = 2'b01;
         end
         R: axi.axi_req.r_ready = 1'b1;
         WR: begin
            axi.axi_req.aw_valid  = ~aw_done_q;
            axi.axi_req.aw.id     = {{(IdWidth-1){1'b0}}, idx_q};
            axi.axi_req.aw.addr   = addr_q;
            axi.axi_req.aw.size   = 3'd3;
            axi.axi_req.aw.burst  = 2'b01;
            axi.axi_req.w_valid   = ~w_done_q;
            axi.axi_req.w.data    = wdata_q;
            axi.axi_req.w.strb    = be_q;
            axi.axi_req.w.last    = 1'b1;
         end
         B: axi.axi_req.b_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q      <= 1'b1;
         idx_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         if (accept) begin
            last_q    <= winner;
            idx_q     <= winner;
            addr_q    <= winner ? req_addr_i[2*AddrWidth-1:AddrWidth] : req_addr_i[AddrWidth-1:0];
            wdata_q   <= winner ? req_wdata_i[2*DataWidth-1:DataWidth] : req_wdata_i[DataWidth-1:0];
            be_q      <= winner ? req_be_i[2*StrbWidth-1:StrbWidth] : req_be_i[StrbWidth-1:0];
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (state_q == WR) begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
         end
         if (r_hs) begin
            rsp_valid_q <= idx_q ? 2'b10 : 2'b01;
            rsp_rdata_q <= axi.axi_resp.r.data;
            rsp_err_q   <= axi.axi_resp.r.resp[1];
         end
         if (b_hs) begin
            rsp_valid_q <= idx_q ? 2'b10 : 2'b01;
            rsp_rdata_q <= '0;
            rsp_err_q   <= axi.axi_resp.b.resp[1];
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_axi_shared_port_arbiter.sv
// tb_axi_shared_port_arbiter: directed bench for axi_shared_port_arbiter.
// The bench plays the AXI slave by driving the response channels cycle by
// cycle and compares every observed output against hand-computed values.
module tb_axi_shared_port_arbiter;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [1:0]    req_valid_i;
   logic [1:0]    req_ready_o;
   logic [1:0]    req_we_i;
   logic [127:0]  req_addr_i;
   logic [127:0]  req_wdata_i;
   logic [15:0]   req_be_i;
   logic [1:0]    rsp_valid_o;
   logic [63:0]   rsp_rdata_o;
   logic          rsp_err_o;

   int            vectors = 0;
   int            miscompares = 0;

   axi_shared_port_arbiter_if bus ();

   axi_shared_port_arbiter #(
      .AddrWidth (64),
      .DataWidth (64),
      .IdWidth   (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_be_i    (req_be_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .axi         (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [1:0] g;
      rst_ni       = 1'b0;
      req_valid_i  = '0;
      req_we_i     = '0;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      req_be_i     = '0;
      bus.axi_resp = '0;

      // Reset values
      #2;
      check("rst_req_ready", req_ready_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rdata", rsp_rdata_o, 0);
      check("rst_err", rsp_err_o, 0);
      check("rst_axi_req", |bus.axi_req, 0);
      @(posedge clk_i);
      tick();
      rst_ni = 1'b1;

      // Round-robin with both requesters reading continuously
      req_we_i   = 2'b00;
      req_addr_i = {64'h0000_0000_0000_0200, 64'h0000_0000_0000_0100};
      req_valid_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         g = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         check("rr_ready", req_ready_o, g);
         tick();
         check("rr_busy_ready", req_ready_o, 0);
         check("rr_ar_valid", bus.axi_req.ar_valid, 1);
         check("rr_ar_id", bus.axi_req.ar.id, (i % 2));
         check("rr_ar_addr", bus.axi_req.ar.addr, (i % 2 == 0) ? 64'h100 : 64'h200);
         bus.axi_resp.ar_ready = 1'b1;
         tick();
         bus.axi_resp.ar_ready = 1'b0;
         check("rr_r_ready", bus.axi_req.r_ready, 1);
         bus.axi_resp.r_valid  = 1'b1;
         bus.axi_resp.r.data   = 64'hA000_0000_0000_0000 + 64'(i);
         bus.axi_resp.r.resp   = 2'b00;
         tick();
         bus.axi_resp.r_valid  = 1'b0;
         check("rr_rsp_valid", rsp_valid_o, g);
         check("rr_rdata", rsp_rdata_o, 64'hA000_0000_0000_0000 + 64'(i));
      end
      req_valid_i = 2'b00;
      tick();
      check("rr_rsp_pulse_end", rsp_valid_o, 0);
      check("rr_idle_ar", bus.axi_req.ar_valid, 0);

      // Single read from requester 0
      req_addr_i  = {64'h0, 64'h0000_0000_8000_0010};
      req_valid_i = 2'b01;
      #1;
      check("rd_ready", req_ready_o, 2'b01);
      tick();
      req_valid_i = 2'b00;
      check("rd_ar_valid", bus.axi_req.ar_valid, 1);
      check("rd_ar_addr", bus.axi_req.ar.addr, 64'h8000_0010);
      check("rd_ar_id", bus.axi_req.ar.id, 0);
      check("rd_ar_len", bus.axi_req.ar.len, 0);
      check("rd_ar_size", bus.axi_req.ar.size, 3);
      check("rd_ar_burst", bus.axi_req.ar.burst, 1);
      check("rd_ar_other", |{bus.axi_req.ar.lock, bus.axi_req.ar.cache, bus.axi_req.ar.prot,
                             bus.axi_req.ar.qos, bus.axi_req.ar.region, bus.axi_req.ar.user}, 0);
      bus.axi_resp.ar_ready = 1'b1;
      tick();
      bus.axi_resp.ar_ready = 1'b0;
      check("rd_r_ready", bus.axi_req.r_ready, 1);
      check("rd_ar_dropped", bus.axi_req.ar_valid, 0);
      check("rd_no_early_rsp", rsp_valid_o, 0);
      bus.axi_resp.r_valid = 1'b1;
      bus.axi_resp.r.data  = 64'hDEAD_BEEF_0123_4567;
      bus.axi_resp.r.resp  = 2'b00;
      tick();
      bus.axi_resp.r_valid = 1'b0;
      check("rd_rsp_valid", rsp_valid_o, 2'b01);
      check("rd_rdata", rsp_rdata_o, 64'hDEAD_BEEF_0123_4567);
      check("rd_err", rsp_err_o, 0);
      tick();
      check("rd_rsp_once", rsp_valid_o, 0);
      check("rd_rdata_hold", rsp_rdata_o, 64'hDEAD_BEEF_0123_4567);

      // Split write handshake from requester 1: AW three cycles before W
      req_we_i    = 2'b10;
      req_addr_i  = {64'h0000_0000_8000_0100, 64'h0};
      req_wdata_i = {64'h1122_3344_5566_7788, 64'h0};
      req_be_i    = {8'hF0, 8'h00};
      req_valid_i = 2'b10;
      #1;
      check("wr_ready", req_ready_o, 2'b10);
      tick();
      req_valid_i = 2'b00;
      check("wr_aw_valid", bus.axi_req.aw_valid, 1);
      check("wr_w_valid", bus.axi_req.w_valid, 1);
      check("wr_aw_id", bus.axi_req.aw.id, 1);
      check("wr_aw_addr", bus.axi_req.aw.addr, 64'h8000_0100);
      check("wr_aw_size", bus.axi_req.aw.size, 3);
      check("wr_wdata", bus.axi_req.w.data, 64'h1122_3344_5566_7788);
      check("wr_wstrb", bus.axi_req.w.strb, 8'hF0);
      check("wr_wlast", bus.axi_req.w.last, 1);
      check("wr_b_ready_early", bus.axi_req.b_ready, 0);
      bus.axi_resp.aw_ready = 1'b1;
      tick();
      bus.axi_resp.aw_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("wr_aw_dropped", bus.axi_req.aw_valid, 0);
         check("wr_w_held", bus.axi_req.w_valid, 1);
         check("wr_b_ready_wait", bus.axi_req.b_ready, 0);
         if (c == 2) bus.axi_resp.w_ready = 1'b1;
         else        tick();
      end
      tick();
      bus.axi_resp.w_ready = 1'b0;
      check("wr_b_ready", bus.axi_req.b_ready, 1);
      check("wr_w_dropped", bus.axi_req.w_valid, 0);
      bus.axi_resp.b_valid = 1'b1;
      bus.axi_resp.b.id    = 4'd1;
      bus.axi_resp.b.resp  = 2'b00;
      tick();
      bus.axi_resp.b_valid = 1'b0;
      check("wr_rsp_valid", rsp_valid_o, 2'b10);
      check("wr_rdata_zero", rsp_rdata_o, 0);
      check("wr_err", rsp_err_o, 0);

      // Error responses: SLVERR read, then DECERR write with same-cycle AW/W
      req_we_i    = 2'b00;
      req_addr_i  = {64'h0, 64'h0000_0000_0000_0040};
      req_valid_i = 2'b01;
      tick();
      req_valid_i = 2'b00;
      bus.axi_resp.ar_ready = 1'b1;
      tick();
      bus.axi_resp.ar_ready = 1'b0;
      bus.axi_resp.r_valid  = 1'b1;
      bus.axi_resp.r.data   = 64'h0BAD_0BAD_0BAD_0BAD;
      bus.axi_resp.r.resp   = 2'b10;
      tick();
      bus.axi_resp.r_valid  = 1'b0;
      check("err_rd_rsp_valid", rsp_valid_o, 2'b01);
      check("err_rd_err", rsp_err_o, 1);
      check("err_rd_rdata", rsp_rdata_o, 64'h0BAD_0BAD_0BAD_0BAD);
      req_we_i    = 2'b01;
      req_wdata_i = {64'h0, 64'h5A5A_5A5A_5A5A_5A5A};
      req_be_i    = {8'h00, 8'hFF};
      req_valid_i = 2'b01;
      #1;
      check("err_wr_b2b_ready", req_ready_o, 2'b01);
      tick();
      req_valid_i = 2'b00;
      check("err_wr_wstrb", bus.axi_req.w.strb, 8'hFF);
      bus.axi_resp.aw_ready = 1'b1;
      bus.axi_resp.w_ready  = 1'b1;
      tick();
      bus.axi_resp.aw_ready = 1'b0;
      bus.axi_resp.w_ready  = 1'b0;
      check("err_wr_b_ready", bus.axi_req.b_ready, 1);
      bus.axi_resp.b_valid = 1'b1;
      bus.axi_resp.b.id    = 4'd0;
      bus.axi_resp.b.resp  = 2'b11;
      tick();
      bus.axi_resp.b_valid = 1'b0;
      check("err_wr_rsp_valid", rsp_valid_o, 2'b01);
      check("err_wr_err", rsp_err_o, 1);
      check("err_wr_rdata", rsp_rdata_o, 0);

      // Reset in the middle of a read while r_ready is high
      req_we_i    = 2'b00;
      req_valid_i = 2'b01;
      tick();
      req_valid_i = 2'b00;
      bus.axi_resp.ar_ready = 1'b1;
      tick();
      bus.axi_resp.ar_ready = 1'b0;
      check("mid_r_ready", bus.axi_req.r_ready, 1);
      #3;
      rst_ni = 1'b0;
      #1;
      check("mid_axi_req", |bus.axi_req, 0);
      check("mid_rsp_valid", rsp_valid_o, 0);
      check("mid_err", rsp_err_o, 0);
      check("mid_rdata", rsp_rdata_o, 0);
      check("mid_req_ready", req_ready_o, 0);
      tick();
      rst_ni = 1'b1;
      // A stray R beat after reset must not be accepted.
      bus.axi_resp.r_valid = 1'b1;
      bus.axi_resp.r.data  = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("post_rst_rsp", rsp_valid_o, 0);
         check("post_rst_r_ready", bus.axi_req.r_ready, 0);
         check("post_rst_ar", bus.axi_req.ar_valid, 0);
      end
      bus.axi_resp.r_valid = 1'b0;
      req_valid_i = 2'b11;
      #1;
      check("post_rst_tie", req_ready_o, 2'b01);
      req_valid_i = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
